// File: rtl/ntt_mult_pipe.sv
// ntt_mult_pipe
//   Two-stage valid/ready pipelined multiplier for NTT residue operands.
//   S1 registers the operand pair and tag. S2 registers the full unsigned
//   product and tag. out_* are driven from S2 registers only. Operands at or
//   above PRIME are still multiplied and forwarded, but they set the sticky
//   range_err flag. When err_clr and a new range error occur in the same
//   cycle, the new error wins.
//
//   Optional feature: define NTT_MULT_PIPE_SKID_EN to add a one-entry input
//   skid buffer. in_ready then comes straight from a flop and has no
//   combinational path from out_ready.
//
// Parameters
//   WIDTH  residue word width (product bus is 2*WIDTH+1 bits)
//   TAG_W  sideband tag width
//   PRIME  modulus; legal operands are 0..PRIME-1
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat present
//   in_ready   beat accepted when in_valid && in_ready at the clock edge
//   in_a/in_b  unsigned residue operands
//   in_tag     sideband tag
//   out_valid  product beat present
//   out_ready  downstream accepts beat
//   out_prod   zero-extended product in_a*in_b
//   out_tag    tag of the beat on out_prod
//   range_err  sticky out-of-range operand flag
//   err_clr    synchronous clear of range_err
module ntt_mult_pipe #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned TAG_W = 8,
    parameter int unsigned PRIME = 65537
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH:0]     out_prod,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 range_err,
    input  logic                 err_clr
);

    localparam logic [WIDTH-1:0] PRIME_W = WIDTH'(PRIME);

    logic                 s1_valid_q;
    logic [WIDTH-1:0]     s1_a_q;
    logic [WIDTH-1:0]     s1_b_q;
    logic [TAG_W-1:0]     s1_tag_q;

    logic                 s2_valid_q;
    logic [2*WIDTH:0]     s2_prod_q;
    logic [TAG_W-1:0]     s2_tag_q;

    logic                 range_err_q;
    logic                 range_err_d;

    logic                 s2_adv;
    logic                 s1_adv;
    logic                 accept;
    logic                 op_bad;

    // Source feeding S1: the live input, or the skid entry when one is held.
    logic                 src_valid;
    logic [WIDTH-1:0]     src_a;
    logic [WIDTH-1:0]     src_b;
    logic [TAG_W-1:0]     src_tag;

    logic [2*WIDTH-1:0]   mul;

    assign s2_adv = ~s2_valid_q | out_ready;
    assign s1_adv = ~s1_valid_q | s2_adv;

`ifdef NTT_MULT_PIPE_SKID_EN
    logic                 skid_valid_q;
    logic                 skid_valid_d;
    logic [WIDTH-1:0]     skid_a_q;
    logic [WIDTH-1:0]     skid_b_q;
    logic [TAG_W-1:0]     skid_tag_q;
    logic                 in_ready_q;

    assign in_ready = in_ready_q;
    assign accept   = in_valid & in_ready_q;

    // A held skid entry always drains into S1 before any new input is taken.
    // in_ready_q is low whenever the skid is full, so accept is never set at
    // the same time as a held entry.
    always_comb begin
        if (skid_valid_q) begin
            src_valid    = 1'b1;
            src_a        = skid_a_q;
            src_b        = skid_b_q;
            src_tag      = skid_tag_q;
            skid_valid_d = ~s1_adv;
        end else begin
            src_valid    = accept;
            src_a        = in_a;
            src_b        = in_b;
            src_tag      = in_tag;
            skid_valid_d = accept & ~s1_adv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_a_q     <= '0;
            skid_b_q     <= '0;
            skid_tag_q   <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= ~skid_valid_d;
            if (accept && !s1_adv) begin
                skid_a_q   <= in_a;
                skid_b_q   <= in_b;
                skid_tag_q <= in_tag;
            end
        end
    end
`else
    // alive_q holds in_ready low while in reset and for no longer than the
    // first edge after release.
    logic                 alive_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
        end
    end

    assign in_ready = alive_q & s1_adv;
    assign accept   = in_valid & in_ready;

    always_comb begin
        src_valid = accept;
        src_a     = in_a;
        src_b     = in_b;
        src_tag   = in_tag;
    end
`endif

    always_comb begin
        op_bad      = accept & ((in_a >= PRIME_W) | (in_b >= PRIME_W));
        range_err_d = op_bad | (range_err_q & ~err_clr);
        mul         = {{WIDTH{1'b0}}, s1_a_q} * {{WIDTH{1'b0}}, s1_b_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_tag_q   <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= src_valid;
            if (src_valid) begin
                s1_a_q   <= src_a;
                s1_b_q   <= src_b;
                s1_tag_q <= src_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_prod_q  <= '0;
            s2_tag_q   <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_prod_q <= {1'b0, mul};
                s2_tag_q  <= s1_tag_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            range_err_q <= 1'b0;
        end else begin
            range_err_q <= range_err_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_prod  = s2_prod_q;
    assign out_tag   = s2_tag_q;
    assign range_err = range_err_q;

endmodule

// File: tb/tb_ntt_mult_pipe.sv
// Testbench for ntt_mult_pipe. The reference model is a FIFO of expected
// (a*b, tag) pairs that is filled on every accepted beat and drained on every
// output handshake, plus a sticky error bit in which set wins over clear.
module tb_ntt_mult_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] in_a = '0;
    logic [17:0] in_b = '0;
    logic [7:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [36:0] out_prod;
    logic [7:0]  out_tag;
    logic        range_err;
    logic        err_clr = 1'b0;

    typedef struct {
        logic [36:0] prod;
        logic [7:0]  tag;
    } beat_t;

    beat_t       exp_q[$];
    logic        model_err = 1'b0;
    logic        hold_pending = 1'b0;
    logic [36:0] hold_prod;
    logic [7:0]  hold_tag;
    int          delivered = 0;
    int          total = 0;
    int          bad = 0;

    ntt_mult_pipe #(.WIDTH(18), .TAG_W(8), .PRIME(65537)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_prod(out_prod), .out_tag(out_tag),
        .range_err(range_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // One cycle: drive at negedge, sample 1 ns later, then update the model.
    task automatic step(input logic v, input logic [17:0] a, input logic [17:0] b,
                        input logic [7:0] t, input logic ordy, input logic clr,
                        output logic acc);
        beat_t       e;
        logic [63:0] p;
        @(negedge clk);
        in_valid = v; in_a = a; in_b = b; in_tag = t;
        out_ready = ordy; err_clr = clr;
        #1;
        if (hold_pending) begin
            total++;
            if (out_valid !== 1'b1 || out_prod !== hold_prod || out_tag !== hold_tag) begin
                bad++;
                $display("FAIL hold: valid=%b prod=%h tag=%h required prod=%h tag=%h",
                         out_valid, out_prod, out_tag, hold_prod, hold_tag);
            end
        end
        total++;
        if (range_err !== model_err) begin
            bad++;
            $display("FAIL range_err: got %b required %b", range_err, model_err);
        end
        if (out_valid === 1'b1 && ordy) begin
            total++;
            delivered++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_beat: prod=%h tag=%h required none", out_prod, out_tag);
            end else begin
                e = exp_q.pop_front();
                if (out_prod !== e.prod || out_tag !== e.tag) begin
                    bad++;
                    $display("FAIL data: prod=%h tag=%h required prod=%h tag=%h",
                             out_prod, out_tag, e.prod, e.tag);
                end
            end
        end
        hold_pending = (out_valid === 1'b1) && !ordy;
        hold_prod = out_prod;
        hold_tag = out_tag;
        acc = v && (in_ready === 1'b1);
        if (acc) begin
            p = 64'(a) * 64'(b);
            e.prod = p[36:0];
            e.tag = t;
            exp_q.push_back(e);
        end
        model_err = (acc && (a >= 18'd65537 || b >= 18'd65537)) || (model_err && !clr);
    endtask

    task automatic drain();
        logic acc;
        int   n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            step(1'b0, '0, '0, '0, 1'b1, 1'b0, acc);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: left=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        logic acc;
        #2;
        total++;
        if (out_valid !== 1'b0 || range_err !== 1'b0 || in_ready !== 1'b0 ||
            out_prod !== '0 || out_tag !== '0) begin
            bad++;
            $display("FAIL reset_state: ov=%b re=%b ir=%b prod=%h tag=%h required 0",
                     out_valid, range_err, in_ready, out_prod, out_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_release: got %b required 1", in_ready);
        end
        step(1'b0, '0, '0, '0, 1'b1, 1'b0, acc);
    endtask

    task automatic test_boundary();
        logic acc;
        step(1'b1, 18'd65536, 18'd65536, 8'h5A, 1'b1, 1'b0, acc);
        total++;
        if (acc !== 1'b1) begin
            bad++;
            $display("FAIL boundary_accept: got %b required 1", acc);
        end
        step(1'b0, '0, '0, '0, 1'b1, 1'b0, acc);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL boundary_early: out_valid=%b required 0", out_valid);
        end
        step(1'b0, '0, '0, '0, 1'b1, 1'b0, acc);
        total++;
        if (out_valid !== 1'b1 || out_prod !== 37'h1_0000_0000 || out_tag !== 8'h5A) begin
            bad++;
            $display("FAIL boundary_value: ov=%b prod=%h tag=%h required 1 100000000 5a",
                     out_valid, out_prod, out_tag);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic acc;
        int   i = 0;
        int   c = 0;
        while ((i < 4 || exp_q.size() != 0) && c < 60) begin
            step(i < 4, 18'(i + 1), 18'd3, 8'(i), !(c >= 2 && c <= 4), 1'b0, acc);
            if (acc) i++;
            c++;
        end
        total++;
        if (i != 4 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL backpressure_done: sent=%0d left=%0d required 4 0", i, exp_q.size());
        end
    endtask

    task automatic test_range();
        logic acc;
        step(1'b1, 18'd65537, 18'd2, 8'h11, 1'b1, 1'b0, acc);
        repeat (3) step(1'b0, '0, '0, '0, 1'b1, 1'b0, acc);
        total++;
        if (range_err !== 1'b1) begin
            bad++;
            $display("FAIL range_sticky: got %b required 1", range_err);
        end
        step(1'b1, 18'd200000, 18'd5, 8'h22, 1'b1, 1'b1, acc);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0, acc);
        total++;
        if (range_err !== 1'b1) begin
            bad++;
            $display("FAIL range_set_wins: got %b required 1", range_err);
        end
        step(1'b0, '0, '0, '0, 1'b1, 1'b1, acc);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0, acc);
        total++;
        if (range_err !== 1'b0) begin
            bad++;
            $display("FAIL range_clear: got %b required 0", range_err);
        end
        drain();
    endtask

    task automatic test_random();
        logic        acc;
        logic [17:0] a;
        logic [17:0] b;
        for (int n = 0; n < 400; n++) begin
            a = ($urandom_range(0, 15) == 0) ? 18'($urandom) : 18'($urandom_range(0, 65536));
            b = ($urandom_range(0, 15) == 0) ? 18'($urandom) : 18'($urandom_range(0, 65536));
            step(($urandom_range(0, 3) != 0), a, b, 8'($urandom),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0), acc);
        end
        drain();
    endtask

    task automatic test_toggle();
        logic acc;
        logic r0;
        int   accepted = 0;
        int   d0;
        d0 = delivered;
        for (int c = 0; c < 40; c++) begin
            step(1'b1, 18'($urandom_range(0, 65536)), 18'($urandom_range(0, 65536)),
                 8'(c), (c % 2 == 0), 1'b0, acc);
            if (acc) accepted++;
`ifdef NTT_MULT_PIPE_SKID_EN
            r0 = in_ready;
            out_ready = ~out_ready;
            #1;
            total++;
            if (in_ready !== r0) begin
                bad++;
                $display("FAIL ready_comb_path: got %b required %b", in_ready, r0);
            end
            out_ready = ~out_ready;
            #1;
`else
            r0 = 1'b0;
`endif
        end
        total++;
        if (delivered - d0 < 17 || accepted < 17) begin
            bad++;
            $display("FAIL toggle_throughput: delivered=%0d accepted=%0d required >=17 each",
                     delivered - d0, accepted);
        end
        drain();
    endtask

    task automatic test_reset_midstream();
        logic acc;
        step(1'b1, 18'd70000, 18'd1, 8'h01, 1'b0, 1'b0, acc);
        step(1'b1, 18'd7, 18'd9, 8'h02, 1'b0, 1'b0, acc);
        step(1'b1, 18'd8, 18'd9, 8'h03, 1'b0, 1'b0, acc);
        total++;
        if (out_valid !== 1'b1 || range_err !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset: ov=%b re=%b required 1 1", out_valid, range_err);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || range_err !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: ov=%b re=%b ir=%b required 0 0 0",
                     out_valid, range_err, in_ready);
        end
        exp_q.delete();
        model_err = 1'b0;
        hold_pending = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, '0, '0, '0, 1'b1, 1'b0, acc);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_midreset: got %b required 1", in_ready);
        end
        step(1'b1, 18'd1234, 18'd5678, 8'hC3, 1'b1, 1'b0, acc);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0, acc);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stale_beat: out_valid=%b required 0", out_valid);
        end
        step(1'b0, '0, '0, '0, 1'b1, 1'b0, acc);
        total++;
        if (out_valid !== 1'b1 || out_prod !== 37'd7006652 || out_tag !== 8'hC3) begin
            bad++;
            $display("FAIL post_reset_beat: ov=%b prod=%0d tag=%h required 1 7006652 c3",
                     out_valid, out_prod, out_tag);
        end
        repeat (4) step(1'b0, '0, '0, '0, 1'b1, 1'b0, acc);
        drain();
    endtask

    initial begin
        test_reset();
        test_boundary();
        test_backpressure();
        test_range();
        test_random();
        test_toggle();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
